dlsc_pcie_s6_outbound_write_split: RTL

Outbound write segmenter for the Spartan-6 PCIe bridge. It accepts one write command (DW address, DW count, first/last byte enables) plus its DW data stream. It splits the command into memory-write TLP segments that respect Max_Payload_Size and never cross a 4 KB boundary. It sits directly upstream of the outbound TLP generator, driving its write-header port (`wr_tlp_h_*`) and write-data port (`wr_tlp_d_*`).

---
 rtl/dlsc_pcie_s6_outbound_write_split_if.sv | 40 ++++
 rtl/dlsc_pcie_s6_outbound_write_split.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_s6_outbound_write_split_if.sv
// Handshake bundle of the outbound write segmenter: command/data in, segment header/data out.
// The slave modport is the segmenter's view; master is the surrounding logic's view.
interface dlsc_pcie_s6_outbound_write_split_if #(
  parameter int ADDR = 32,
  parameter int LEN  = 8
);
  logic            cmd_ready;
  logic            cmd_valid;
  logic [ADDR-1:2] cmd_addr;
  logic [LEN-1:0]  cmd_len;
  logic [3:0]      cmd_be_first;
  logic [3:0]      cmd_be_last;
  logic            in_ready;
  logic            in_valid;
  logic [31:0]     in_data;
  logic            tlp_h_ready;
  logic            tlp_h_valid;
  logic [ADDR-1:2] tlp_h_addr;
  logic [9:0]      tlp_h_len;
  logic [3:0]      tlp_h_be_first;
  logic [3:0]      tlp_h_be_last;
  logic            tlp_d_ready;
  logic            tlp_d_valid;
  logic [31:0]     tlp_d_data;
  logic            tlp_d_last;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_be_first, cmd_be_last,
    input  in_valid, in_data, tlp_h_ready, tlp_d_ready,
    output cmd_ready, in_ready, tlp_h_valid, tlp_h_addr, tlp_h_len,
    output tlp_h_be_first, tlp_h_be_last, tlp_d_valid, tlp_d_data, tlp_d_last
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_be_first, cmd_be_last,
    output in_valid, in_data, tlp_h_ready, tlp_d_ready,
    input  cmd_ready, in_ready, tlp_h_valid, tlp_h_addr, tlp_h_len,
    input  tlp_h_be_first, tlp_h_be_last, tlp_d_valid, tlp_d_data, tlp_d_last
  );
endinterface

// File: rtl/dlsc_pcie_s6_outbound_write_split.sv
// Outbound write segmenter: splits one write command into MPS-sized segments that never cross
// a 4 KB boundary. Header and data sides are decoupled by a small segment-length FIFO.
module dlsc_pcie_s6_outbound_write_split #(
  parameter int ADDR       = 32,
  parameter int LEN        = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] max_payload_size,
  dlsc_pcie_s6_outbound_write_split_if.slave bus
);

  localparam int RW = ((LEN + 1) > 11) ? (LEN + 1) : 11;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [RW-1:0] SEG_ONE = {{(RW-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:2] addr_q, addr_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [3:0]      be_first_q, be_first_d;
  logic [3:0]      be_last_q, be_last_d;
  logic            first_q, first_d;
  logic            single_q, single_d;
  logic [2:0]      mps_q, mps_d;
  logic [10:0]     mem_q [FIFO_DEPTH];
  logic [10:0]     mem_d [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [9:0]      cnt_q, cnt_d;

  logic [RW-1:0] mps_dw_s, room_s, seg_a_s, seg_s;
  logic [3:0]    bf_s, bl_s;
  logic [10:0]   head_s, head_m1_s;
  logic          last_seg_s, fifo_full_s, fifo_empty_s;
  logic          h_fire_s, d_fire_s, d_last_s;

  // MPS encoding to DW count; anything above 2 behaves as 128 DW
  always_comb begin
    case (mps_q)
      3'd0:    mps_dw_s = RW'(11'd32);
      3'd1:    mps_dw_s = RW'(11'd64);
      default: mps_dw_s = RW'(11'd128);
    endcase
  end

  assign room_s     = RW'(11'd1024 - {1'b0, addr_q[11:2]});
  assign seg_a_s    = (mps_dw_s < rem_q) ? mps_dw_s : rem_q;
  assign seg_s      = (room_s < seg_a_s) ? room_s : seg_a_s;
  assign last_seg_s = (seg_s == rem_q);

  assign bf_s = first_q ? be_first_q : 4'hF;
  assign bl_s = last_seg_s ? be_last_q : 4'hF;

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_s       = mem_q[rd_ptr_q[PW-1:0]];
  assign head_m1_s    = head_s - 11'd1;

  assign bus.cmd_ready      = (state_q == ST_IDLE);
  assign bus.tlp_h_valid    = (state_q == ST_SPLIT) && !fifo_full_s;
  assign bus.tlp_h_addr     = addr_q;
  assign bus.tlp_h_len      = seg_s[9:0];
  assign bus.tlp_h_be_first = single_q ? be_first_q :
                              ((seg_s == SEG_ONE) ? (bf_s & bl_s) : bf_s);
  assign bus.tlp_h_be_last  = (single_q || (seg_s == SEG_ONE)) ? 4'h0 : bl_s;

  assign d_last_s        = !fifo_empty_s && ({1'b0, cnt_q} == head_m1_s);
  assign bus.tlp_d_valid = bus.in_valid && !fifo_empty_s;
  assign bus.in_ready    = bus.tlp_d_ready && !fifo_empty_s;
  assign bus.tlp_d_data  = bus.in_data;
  assign bus.tlp_d_last  = d_last_s;

  assign h_fire_s = bus.tlp_h_valid && bus.tlp_h_ready;
  assign d_fire_s = bus.in_valid && bus.tlp_d_ready && !fifo_empty_s;

  // Header FSM: latch a command, then walk it segment by segment
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    be_first_d = be_first_q;
    be_last_d  = be_last_q;
    first_d    = first_q;
    single_d   = single_q;
    mps_d      = max_payload_size;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = ST_SPLIT;
          addr_d     = bus.cmd_addr;
          rem_d      = RW'(bus.cmd_len) + SEG_ONE;
          be_first_d = bus.cmd_be_first;
          be_last_d  = bus.cmd_be_last;
          first_d    = 1'b1;
          single_d   = (bus.cmd_len == {LEN{1'b0}});
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SPLIT: begin
        if (h_fire_s) begin
          addr_d  = addr_q + (ADDR-2)'(seg_s);
          rem_d   = rem_q - seg_s;
          first_d = 1'b0;
          state_d = last_seg_s ? ST_IDLE : ST_SPLIT;
        end else begin
          state_d = ST_SPLIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Length FIFO push/pop and the beat counter of the head segment
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (h_fire_s) begin
      mem_d[wr_ptr_q[PW-1:0]] = seg_s[10:0];
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (d_fire_s) begin
      if (d_last_s) begin
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        cnt_d    = 10'd0;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= {(ADDR-2){1'b0}};
      rem_q      <= {RW{1'b0}};
      be_first_q <= 4'h0;
      be_last_q  <= 4'h0;
      first_q    <= 1'b0;
      single_q   <= 1'b0;
      mps_q      <= 3'd0;
      mem_q      <= '{default: 11'd0};
      wr_ptr_q   <= {(PW+1){1'b0}};
      rd_ptr_q   <= {(PW+1){1'b0}};
      cnt_q      <= 10'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      be_first_q <= be_first_d;
      be_last_q  <= be_last_d;
      first_q    <= first_d;
      single_q   <= single_d;
      mps_q      <= mps_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
